multi_mode_ff_bank: RTL and testbench

// - WIDTH-channel register bank; each bit behaves as a D, T, SR or JK flip-flop, chosen at run time by mode.
// - Successor to the single-bit SR flip-flop: parametrised width, selectable invalid-SR policy,

---
 rtl/multi_mode_ff_bank.sv | 121 ++++++++++++
 tb/tb_multi_mode_ff_bank.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/multi_mode_ff_bank.sv
// multi_mode_ff_bank: WIDTH-channel register bank. Each channel acts as a
// D, T, SR or JK flip-flop, selected at run time by mode. It also keeps
// sticky per-bit SR-conflict flags, one-cycle change strobes and a
// saturating count of the edges at which any bit changed.
module multi_mode_ff_bank #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               SR_POLICY = 0,
  parameter int               CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic [WIDTH-1:0] err,
  output logic [WIDTH-1:0] chg,
  output logic [CNT_W-1:0] chg_cnt
);

  typedef enum logic [1:0] {
    MODE_D  = 2'b00,
    MODE_T  = 2'b01,
    MODE_SR = 2'b10,
    MODE_JK = 2'b11
  } mode_t;

  // Out-of-range policy values fall back to "hold".
  localparam int POL = (SR_POLICY >= 0 && SR_POLICY <= 2) ? SR_POLICY : 0;

  mode_t mode_e;
  assign mode_e = mode_t'(mode);

  logic [WIDTH-1:0] q_q,   q_d;
  logic [WIDTH-1:0] err_q, err_d;
  logic [WIDTH-1:0] chg_q, chg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Candidate next value of every channel, assuming the bank is enabled.
  logic [WIDTH-1:0] q_nxt;
  // Channels that see S=R=1 in SR mode while enabled.
  logic [WIDTH-1:0] err_set;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_chan
      logic nb;

      // Per-channel flip-flop characteristic equation for the current mode.
      always_comb begin
        nb = q_q[gi];
        case (mode_e)
          MODE_D:  nb = a[gi];
          MODE_T:  nb = q_q[gi] ^ a[gi];
          MODE_SR: begin
            case ({a[gi], b[gi]})
              2'b10:   nb = 1'b1;
              2'b01:   nb = 1'b0;
              2'b11: begin
                if (POL == 1)      nb = 1'b1;
                else if (POL == 2) nb = 1'b0;
                else               nb = q_q[gi];
              end
              default: nb = q_q[gi];
            endcase
          end
          MODE_JK: begin
            case ({a[gi], b[gi]})
              2'b10:   nb = 1'b1;
              2'b01:   nb = 1'b0;
              2'b11:   nb = ~q_q[gi];
              default: nb = q_q[gi];
            endcase
          end
          default: nb = q_q[gi];
        endcase
      end

      assign q_nxt[gi]   = nb;
      assign err_set[gi] = en && (mode_e == MODE_SR) && a[gi] && b[gi];
    end
  endgenerate

  // Bank-wide next state: enable gating, sticky errors, strobes, counter.
  always_comb begin
    q_d   = en ? q_nxt : q_q;
    chg_d = q_d ^ q_q;
    // A fresh conflict in the clearing cycle must survive the clear.
    err_d = (err_clr ? '0 : err_q) | err_set;
    cnt_d = cnt_q;
    if ((|chg_d) && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q   <= RESET_VAL;
      err_q <= '0;
      chg_q <= '0;
      cnt_q <= '0;
    end else begin
      q_q   <= q_d;
      err_q <= err_d;
      chg_q <= chg_d;
      cnt_q <= cnt_d;
    end
  end

  assign q       = q_q;
  assign q_n     = ~q_q;
  assign err     = err_q;
  assign chg     = chg_q;
  assign chg_cnt = cnt_q;

endmodule

// File: tb/tb_multi_mode_ff_bank.sv
// Directed bench for multi_mode_ff_bank: four instances share one stimulus
// stream (SR policy 0/1/2 and a 3-bit change counter).
module tb_multi_mode_ff_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [7:0] a, b;
  logic       err_clr;

  logic [7:0] q0, qn0, err0, chg0, cnt0;
  logic [7:0] q1, qn1, err1, chg1, cnt1;
  logic [7:0] q2, qn2, err2, chg2, cnt2;
  logic [7:0] q3, qn3, err3, chg3;
  logic [2:0] cnt3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multi_mode_ff_bank #(.WIDTH(8), .SR_POLICY(0), .CNT_W(8)) u0 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .err_clr(err_clr),
    .q(q0), .q_n(qn0), .err(err0), .chg(chg0), .chg_cnt(cnt0));
  multi_mode_ff_bank #(.WIDTH(8), .SR_POLICY(1), .CNT_W(8)) u1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .err_clr(err_clr),
    .q(q1), .q_n(qn1), .err(err1), .chg(chg1), .chg_cnt(cnt1));
  multi_mode_ff_bank #(.WIDTH(8), .SR_POLICY(2), .CNT_W(8)) u2 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .err_clr(err_clr),
    .q(q2), .q_n(qn2), .err(err2), .chg(chg2), .chg_cnt(cnt2));
  multi_mode_ff_bank #(.WIDTH(8), .SR_POLICY(0), .CNT_W(3)) u3 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .err_clr(err_clr),
    .q(q3), .q_n(qn3), .err(err3), .chg(chg3), .chg_cnt(cnt3));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-14s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One rising edge, then settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'b00; a = 8'h00; b = 8'h00; err_clr = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_q",    q0,   8'h00);
    check("rst_qn",   qn0,  8'hFF);
    check("rst_err",  err0, 8'h00);
    check("rst_chg",  chg0, 8'h00);
    check("rst_cnt",  cnt0, 8'h00);

    // Load A5 in D mode, then assert reset asynchronously mid-cycle.
    en = 1'b1; mode = 2'b00; a = 8'hA5;
    tick();
    check("d_q",      q0,   8'hA5);
    check("d_chg",    chg0, 8'hA5);
    check("d_cnt",    cnt0, 8'h01);
    rst = 1'b1;
    #1;
    check("arst_q",   q0,   8'h00);
    check("arst_qn",  qn0,  8'hFF);
    check("arst_cnt", cnt0, 8'h00);
    check("arst_chg", chg0, 8'h00);
    en = 1'b0;
    #1;
    rst = 1'b0;

    // SR mode, policy 0 on u0.
    en = 1'b1; mode = 2'b10; a = 8'h0F; b = 8'h00;
    tick();
    check("sr_set_q",  q0,   8'h0F);
    a = 8'h00; b = 8'h03;
    tick();
    check("sr_rst_q",  q0,   8'h0C);
    check("sr_rst_chg", chg0, 8'h03);
    a = 8'h01; b = 8'h01;
    tick();
    check("sr_11_q",   q0,   8'h0C);
    check("sr_11_err", err0, 8'h01);
    check("sr_11_chg", chg0, 8'h00);
    check("sr_11_cnt", cnt0, 8'h02);
    check("sr_11_q1",  q1,   8'h0D);
    check("sr_11_q2",  q2,   8'h0C);

    // Clear q and err, then S=R=1 on all bits under each policy.
    mode = 2'b00; a = 8'h00; b = 8'h00; err_clr = 1'b1;
    tick();
    check("clr_err",   err1, 8'h00);
    err_clr = 1'b0; mode = 2'b10; a = 8'hFF; b = 8'hFF;
    tick();
    check("pol0_q",    q0,   8'h00);
    check("pol1_q",    q1,   8'hFF);
    check("pol2_q",    q2,   8'h00);
    check("pol1_err",  err1, 8'hFF);
    check("pol2_err",  err2, 8'hFF);
    check("pol1_chg",  chg1, 8'hFF);

    // JK toggle from 3C.
    mode = 2'b00; a = 8'h3C; b = 8'h00;
    tick();
    mode = 2'b11; a = 8'hFF; b = 8'hFF;
    tick();
    check("jk_q",      q0,   8'hC3);
    check("jk_chg",    chg0, 8'hFF);
    check("jk_err",    err0, 8'hFF);

    // T mode: q[0] toggles on four edges.
    mode = 2'b00; a = 8'h00; b = 8'h00;
    tick();
    mode = 2'b01; a = 8'h01;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t_q",   q0,   (i % 2 == 0) ? 8'h01 : 8'h00);
      check("t_chg", chg0, 8'h01);
    end

    // Enable low: q holds and no strobe.
    mode = 2'b00; a = 8'h5A;
    tick();
    en = 1'b0; a = 8'hFF;
    tick();
    check("en0_q",     q0,   8'h5A);
    check("en0_qn",    qn0,  8'hA5);
    check("en0_chg",   chg0, 8'h00);

    // Clear and set on bit 2 in the same cycle: set wins.
    en = 1'b1; mode = 2'b10; a = 8'h04; b = 8'h04; err_clr = 1'b1;
    tick();
    check("clrset_err", err0, 8'h04);
    check("clrset_q",   q0,   8'h5A);
    // err_clr still acts with the bank disabled.
    en = 1'b0;
    tick();
    check("clr_en0",    err0, 8'h00);
    err_clr = 1'b0;

    // Fresh reset, then ten toggles of q[0]: 3-bit counter saturates at 7.
    rst = 1'b1;
    #1;
    rst = 1'b0;
    en = 1'b1; mode = 2'b01; a = 8'h01; b = 8'h00;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("cnt3", cnt3, (i < 7) ? i : 7);
    end
    check("cnt8", cnt0, 8'd10);
    en = 1'b0;
    tick();
    check("cnt3_hold", cnt3, 3'd7);
    check("cnt8_hold", cnt0, 8'd10);
    check("q3_final",  q3,   8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
